// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with self-generated bit timing.
// Serial line in, one parallel word plus parity/framing status out per frame.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit decision is a 2-of-3 vote
// over three consecutive samples around mid-bit, one cycle later than the single sample.
module uart_rx_frame #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rx_pin_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done_sig,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CLK_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W   = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision taken once the third vote sample (mid-bit + 1) is on the line.
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(CLK_DIV / 2 + 1);
`else
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(CLK_DIV / 2);
`endif
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic                 r_sync1, r_sync2, r_sync_prev;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_acc, r_perr, r_ferr, r_armed;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_done, r_parity_err, r_frame_err, r_busy;

  logic [2:0] w_state_d;
  logic       w_fall, w_bit, w_samp, w_bit_end, w_entry;
  logic       w_start_ok, w_shift, w_par_chk, w_stop_smp, w_load_out, w_ferr_final;

  assign w_fall       = r_sync_prev & ~r_sync2;
  assign w_samp       = (r_cnt == CNT_SAMPLE);
  assign w_bit_end    = (r_cnt == CNT_LAST);
  assign w_entry      = (w_state_d != r_state);
  assign w_ferr_final = r_ferr | ~w_bit;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_v0, r_v1;

  // Vote history: line value at the two cycles preceding the decision cycle.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0 <= 1'b1;
      r_v1 <= 1'b1;
    end else begin
      r_v0 <= r_sync2;
      r_v1 <= r_v0;
    end
  end

  assign w_bit = (r_sync2 & r_v0) | (r_sync2 & r_v1) | (r_v0 & r_v1);
`else
  assign w_bit = r_sync2;
`endif

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= rx_pin_in;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  // Next-state decode and per-cycle strobes for the datapath.
  always_comb begin
    w_state_d  = r_state;
    w_start_ok = 1'b0;
    w_shift    = 1'b0;
    w_par_chk  = 1'b0;
    w_stop_smp = 1'b0;
    w_load_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_en && r_armed && w_fall) w_state_d = S_START;
      end
      S_START: begin
        if (w_samp) begin
          if (w_bit) w_state_d = S_IDLE;
          else       w_start_ok = 1'b1;
        end else if (w_bit_end) begin
          w_state_d = S_DATA;
        end
      end
      S_DATA: begin
        w_shift = w_samp;
        if (w_bit_end && (r_bit_cnt == DATA_LAST)) begin
          w_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_par_chk = w_samp;
        if (w_bit_end) w_state_d = S_STOP;
      end
      S_STOP: begin
        if (w_samp) begin
          w_stop_smp = 1'b1;
          // Finish at mid-bit of the last stop bit so a following start edge is not missed.
          if (r_bit_cnt == STOP_LAST) begin
            w_state_d  = S_DONE;
            w_load_out = 1'b1;
          end
        end
      end
      S_DONE:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
    if (!rx_en) begin
      w_state_d  = S_IDLE;
      w_start_ok = 1'b0;
      w_load_out = 1'b0;
    end
  end

  // State, baud counter (cleared on every state change) and bit counter.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_entry || (r_state == S_IDLE) || w_bit_end) r_cnt <= '0;
      else                                            r_cnt <= r_cnt + CNT_ONE;
      if (w_entry)                    r_bit_cnt <= '0;
      else if (w_shift || w_stop_smp) r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

  // Frame datapath: shift register (LSB first), running parity, working error flags.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_par_acc <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else if (w_entry && (w_state_d == S_START)) begin
      r_par_acc <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      if (w_shift) begin
        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
        r_par_acc <= r_par_acc ^ w_bit;
      end
      if (w_par_chk)            r_perr <= ((r_par_acc ^ w_bit) != PAR_ODD);
      if (w_stop_smp && !w_bit) r_ferr <= 1'b1;
    end
  end

  // Output registers: word and flags update together and hold until the next frame.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= '0;
      r_done       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_done <= w_load_out;
      if (w_load_out) begin
        r_rx_data    <= r_shift;
        r_parity_err <= r_perr;
        r_frame_err  <= w_ferr_final;
      end
      if (w_start_ok)                r_busy <= 1'b1;
      else if (w_load_out || !rx_en) r_busy <= 1'b0;
    end
  end

  // After a framing error, wait for the line to return high before accepting a new edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                           r_armed <= 1'b1;
    else if (w_load_out && w_ferr_final)  r_armed <= 1'b0;
    else if (r_sync2)                     r_armed <= 1'b1;
  end

  assign rx_data     = r_rx_data;
  assign rx_done_sig = r_done;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign rx_busy     = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: dut0 is 8N1, dut1 is 8E1. A frame-level model predicts the
// word, flags and approximate completion cycle of each frame; a per-cycle compare process
// checks pulses, held outputs and idle busy against it.
module tb_uart_rx_frame;

  localparam int ClkFreq = 50_000_000;
  localparam int Baud    = 115200;
  localparam int Div     = ClkFreq / Baud;
  localparam int Half    = Div / 2;
  localparam int Tol     = 3;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int Vote = 1;
`else
  localparam int Vote = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, rx_en, pin0, pin1;
  logic [7:0] d0_data, d1_data;
  logic       d0_done, d0_perr, d0_ferr, d0_busy;
  logic       d1_done, d1_perr, d1_ferr, d1_busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] hist0[$];
  logic [7:0] m_data [2];
  logic       m_perr [2];
  logic       m_ferr [2];
  bit         frame_active [2];
  int         pulses [2];
  logic [7:0] drop_byte;

  uart_rx_frame #(
    .CLK_FREQ (ClkFreq), .BAUD_RATE(Baud), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut0 (
    .sys_clk    (clk),
    .rst_n      (rst_n),
    .rx_en      (rx_en),
    .rx_pin_in  (pin0),
    .rx_data    (d0_data),
    .rx_done_sig(d0_done),
    .parity_err (d0_perr),
    .frame_err  (d0_ferr),
    .rx_busy    (d0_busy)
  );

  uart_rx_frame #(
    .CLK_FREQ (ClkFreq), .BAUD_RATE(Baud), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut1 (
    .sys_clk    (clk),
    .rst_n      (rst_n),
    .rx_en      (rx_en),
    .rx_pin_in  (pin1),
    .rx_data    (d1_data),
    .rx_done_sig(d1_done),
    .parity_err (d1_perr),
    .frame_err  (d1_ferr),
    .rx_busy    (d1_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_win(input string name, input int act, input int exp);
    checks++;
    if (act < exp - Tol || act > exp + Tol) begin
      errors++;
      $display("FAIL %s: got cycle %0d expected %0d +/- %0d", name, act, exp, Tol);
    end
  endtask

  task automatic check_port(input int id, input logic done, input logic [7:0] data,
                            input logic pe, input logic fe, input logic busy);
    exp_t e;
    bit   have;
    if (id == 0) begin
      have = (q0.size() > 0);
      if (have) e = q0[0];
    end else begin
      have = (q1.size() > 0);
      if (have) e = q1[0];
    end
    if (done) begin
      pulses[id]++;
      if (id == 0) hist0.push_back(data);
      chk($sformatf("pulse_expected%0d", id), {31'b0, have}, 32'd1);
      if (have) begin
        if (id == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
        chk_win($sformatf("done_time%0d", id), cyc, e.t);
        chk($sformatf("busy_at_done%0d", id), {31'b0, busy}, 32'd0);
        m_data[id] = e.data;
        m_perr[id] = e.perr;
        m_ferr[id] = e.ferr;
      end
    end else if (have && cyc > e.t + Tol) begin
      chk($sformatf("pulse_missing%0d", id), {31'b0, done}, 32'd1);
      if (id == 0) void'(q0.pop_front());
      else         void'(q1.pop_front());
    end
    chk($sformatf("data_held%0d", id), {24'b0, data}, {24'b0, m_data[id]});
    chk($sformatf("perr_held%0d", id), {31'b0, pe}, {31'b0, m_perr[id]});
    chk($sformatf("ferr_held%0d", id), {31'b0, fe}, {31'b0, m_ferr[id]});
    if (!done && !have && !frame_active[id])
      chk($sformatf("busy_idle%0d", id), {31'b0, busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_port(0, d0_done, d0_data, d0_perr, d0_ferr, d0_busy);
      check_port(1, d1_done, d1_data, d1_perr, d1_ferr, d1_busy);
    end
  end

  task automatic set_pin(input int id, input logic v);
    if (id == 0) pin0 = v;
    else         pin1 = v;
  endtask

  // One bit period starting just after a rising clock edge; optional 1-cycle mid-bit glitch.
  task automatic hold_bit(input int id, input logic v, input bit glitch);
    set_pin(id, v);
    if (glitch) begin
      repeat (Half + 1) @(posedge clk);
      #1 set_pin(id, ~v);
      @(posedge clk);
      #1 set_pin(id, v);
      repeat (Div - Half - 2) @(posedge clk);
    end else begin
      repeat (Div) @(posedge clk);
    end
    #1;
  endtask

  // pbit < 0: no parity bit (dut0). Otherwise the explicit parity bit, checked as even parity.
  task automatic send_frame(input int id, input logic [7:0] data, input int pbit,
                            input logic stop_v, input int glitch_bit);
    exp_t e;
    int   c0;
    int   last_pos;
    @(posedge clk);
    #1;
    c0       = cyc;
    last_pos = (pbit >= 0) ? 10 : 9;
    e.data   = data;
    e.perr   = (pbit >= 0) && ((($countones(data) + pbit) % 2) != 0);
    e.ferr   = !stop_v;
    // Mid-point of the last stop bit plus synchroniser, edge and output register latency.
    e.t      = c0 + last_pos * Div + Half + 4 + Vote;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
    hold_bit(id, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(id, data[i], glitch_bit == i);
    if (pbit >= 0) hold_bit(id, pbit[0], 1'b0);
    hold_bit(id, stop_v, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_en = 1'b0;
    pin0  = 1'b1;
    pin1  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_data[i] = 8'h00;
      m_perr[i] = 1'b0;
      m_ferr[i] = 1'b0;
      frame_active[i] = 1'b0;
      pulses[i] = 0;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_data0", {24'b0, d0_data}, 32'h0);
    chk("rst_done0", {31'b0, d0_done}, 32'h0);
    chk("rst_ferr0", {31'b0, d0_ferr}, 32'h0);
    chk("rst_busy0", {31'b0, d0_busy}, 32'h0);
    chk("rst_data1", {24'b0, d1_data}, 32'h0);
    chk("rst_perr1", {31'b0, d1_perr}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rx_en  = 1'b1;
    chk_en = 1'b1;
    repeat (20) @(posedge clk);

    // 8N1 0xA5
    send_frame(0, 8'hA5, -1, 1'b1, -1);
    repeat (Div) @(posedge clk);
    chk("a5_data", {24'b0, d0_data}, 32'hA5);
    chk("a5_perr", {31'b0, d0_perr}, 32'h0);
    chk("a5_ferr", {31'b0, d0_ferr}, 32'h0);
    chk("a5_pulses", pulses[0], 32'd1);

    // Even parity: 0x3C has four ones, so parity bit 1 is wrong and 0 is right
    send_frame(1, 8'h3C, 1, 1'b1, -1);
    repeat (Div) @(posedge clk);
    chk("par_bad_data", {24'b0, d1_data}, 32'h3C);
    chk("par_bad_perr", {31'b0, d1_perr}, 32'h1);
    send_frame(1, 8'h3C, 0, 1'b1, -1);
    repeat (Div) @(posedge clk);
    chk("par_good_perr", {31'b0, d1_perr}, 32'h0);
    chk("par_pulses", pulses[1], 32'd2);

    // 0x81 with low stop bit, line then held low for 20 bit times
    send_frame(0, 8'h81, -1, 1'b0, -1);
    set_pin(0, 1'b0);
    repeat (20 * Div) @(posedge clk);
    #1 set_pin(0, 1'b1);
    repeat (2 * Div) @(posedge clk);
    chk("brk_data", {24'b0, d0_data}, 32'h81);
    chk("brk_ferr", {31'b0, d0_ferr}, 32'h1);
    chk("brk_pulses", pulses[0], 32'd2);

    // 100-cycle low glitch on idle line: false start
    @(posedge clk);
    #1 set_pin(0, 1'b0);
    repeat (100) @(posedge clk);
    #1 set_pin(0, 1'b1);
    repeat (2 * Div) @(posedge clk);
    chk("glitch_pulses", pulses[0], 32'd2);
    chk("glitch_busy", {31'b0, d0_busy}, 32'h0);

    // Back-to-back frames, no idle gap
    send_frame(0, 8'h55, -1, 1'b1, -1);
    send_frame(0, 8'hAA, -1, 1'b1, -1);
    repeat (Div) @(posedge clk);
    chk("b2b_pulses", pulses[0], 32'd4);
    chk("b2b_data", {24'b0, d0_data}, 32'hAA);
    chk("b2b_ferr", {31'b0, d0_ferr}, 32'h0);
    chk("hist_size", hist0.size(), 32'd4);
    if (hist0.size() >= 4) chk("b2b_first", {24'b0, hist0[2]}, 32'h55);

    // rx_en dropped during data bit 4
    drop_byte = 8'h0F;
    frame_active[0] = 1'b1;
    @(posedge clk);
    #1;
    hold_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) hold_bit(0, drop_byte[i], 1'b0);
    set_pin(0, drop_byte[4]);
    repeat (Half) @(posedge clk);
    #1;
    chk("drop_busy_before", {31'b0, d0_busy}, 32'h1);
    rx_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("drop_busy_after", {31'b0, d0_busy}, 32'h0);
    frame_active[0] = 1'b0;
    repeat (Div - Half) @(posedge clk);
    #1;
    for (int i = 5; i < 8; i++) hold_bit(0, drop_byte[i], 1'b0);
    hold_bit(0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1 rx_en = 1'b1;
    repeat (Div) @(posedge clk);
    chk("drop_pulses", pulses[0], 32'd4);
    chk("drop_data", {24'b0, d0_data}, 32'hAA);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-cycle low glitch at the middle of data bit 3 is outvoted
    send_frame(0, 8'hFF, -1, 1'b1, 3);
    repeat (Div) @(posedge clk);
    chk("vote_data", {24'b0, d0_data}, 32'hFF);
    chk("vote_pulses", pulses[0], 32'd5);
`endif

    for (int i = 0; i < 5 * Div && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    chk("queues_drained", q0.size() + q1.size(), 32'd0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
